// File: rtl/hilo_muldiv_ctrl_if.sv
// Execute-stage <-> HI/LO mult/div sequencer signal bundle.
// Latency: n/a (wiring only).
// Backpressure: the execute stage must stall issue while Busy is high.
// Optional Div_zero member exists only when MULDIV_DIV0_TRAP_EN is defined.
interface hilo_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [5:0]       Function_opcode;
  logic             Flush;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI_result;
  logic [WIDTH-1:0] LO_result;
`ifdef MULDIV_DIV0_TRAP_EN
  logic             Div_zero;
`endif

  // Execute stage side: issues ops, observes status and HI/LO.
  modport master (
    output Start, Function_opcode, Flush, Read_data_1, Read_data_2,
`ifdef MULDIV_DIV0_TRAP_EN
    input  Div_zero,
`endif
    input  Busy, Done, HI_result, LO_result
  );

  // Sequencer side.
  modport slave (
    input  Start, Function_opcode, Flush, Read_data_1, Read_data_2,
`ifdef MULDIV_DIV0_TRAP_EN
    output Div_zero,
`endif
    output Busy, Done, HI_result, LO_result
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle mult/multu/div/divu sequencer; owns architectural HI/LO (mthi/mtlo write directly).
// Latency: Start -> Done is WIDTH+2 cycles; mthi/mtlo take effect at the Start edge.
// Backpressure: Busy high while an op is in flight; Start during Busy is dropped, Flush aborts.
// Optional: define MULDIV_DIV0_TRAP_EN to trap divide-by-zero (Div_zero pulse, HI/LO untouched).
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  hilo_muldiv_ctrl_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;

  // Iteration registers, shared by multiplier and divider:
  //   mul: hi_acc = running high half, lo_acc = multiplier shifting out / product low half
  //   div: hi_acc = partial remainder, lo_acc = dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] hi_acc_q, lo_acc_q;
  logic [WIDTH-1:0] op_q;        // |multiplicand| or |divisor|
  logic             is_div_q;
  logic             neg_lo_q;    // negate product / quotient at fix-up
  logic             neg_hi_q;    // negate high product / remainder at fix-up
  logic             div0_q;      // latched divisor == 0
`ifndef MULDIV_DIV0_TRAP_EN
  logic [WIDTH-1:0] raw_a_q;     // dividend as issued, returned in HI on divide by zero
`endif

  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
`ifdef MULDIV_DIV0_TRAP_EN
  logic             div_zero_q;
  logic             div_zero_d;
`endif

  // FSM control strobes
  logic accept, iter, fix_we, mthi_we, mtlo_we, done_d;

  // Issue decode
  logic             is_mul_op, is_div_op, is_signed_op, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_mul_op    = (bus.Function_opcode == F_MULT) || (bus.Function_opcode == F_MULTU);
  assign is_div_op    = (bus.Function_opcode == F_DIV)  || (bus.Function_opcode == F_DIVU);
  assign is_signed_op = (bus.Function_opcode == F_MULT) || (bus.Function_opcode == F_DIV);
  assign a_neg        = is_signed_op & bus.Read_data_1[WIDTH-1];
  assign b_neg        = is_signed_op & bus.Read_data_2[WIDTH-1];
  assign a_mag        = a_neg ? -bus.Read_data_1 : bus.Read_data_1;
  assign b_mag        = b_neg ? -bus.Read_data_2 : bus.Read_data_2;
  assign b_zero       = (bus.Read_data_2 == '0);

  // One radix-2 step of shift-add multiply and restoring divide.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  // Next iteration values; the unselected datapath is simply ignored.
  always_comb begin
    mul_sum   = {1'b0, hi_acc_q} + (lo_acc_q[0] ? {1'b0, op_q} : '0);
    div_shift = {hi_acc_q, lo_acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, op_q});
    // When the trial subtraction succeeds the remainder is below the divisor,
    // so the WIDTH-bit wrapped difference is exact.
    div_diff  = div_shift[WIDTH-1:0] - op_q;
    hi_nxt    = '0;
    lo_nxt    = '0;
    if (is_div_q) begin
      hi_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_nxt = {lo_acc_q[WIDTH-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo_acc_q[WIDTH-1:1]};
    end
  end

  // Final sign correction of the unsigned magnitude result.
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // Select mul product halves or div quotient/remainder with signs restored.
  always_comb begin
    prod_mag = {hi_acc_q, lo_acc_q};
    prod_fix = neg_lo_q ? -prod_mag : prod_mag;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      fix_lo = neg_lo_q ? -lo_acc_q : lo_acc_q;
      fix_hi = neg_hi_q ? -hi_acc_q : hi_acc_q;
`ifndef MULDIV_DIV0_TRAP_EN
      // Divide by zero still runs full latency but returns a fixed pattern.
      if (div0_q) begin
        fix_lo = '1;
        fix_hi = raw_a_q;
      end
`endif
    end
  end

  // State register; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle control strobes; Flush beats Start.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    iter    = 1'b0;
    fix_we  = 1'b0;
    mthi_we = 1'b0;
    mtlo_we = 1'b0;
    done_d  = 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
    div_zero_d = 1'b0;
`endif
    if (bus.Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.Start) begin
            if (is_mul_op) begin
              accept  = 1'b1;
              state_d = S_MUL;
            end else if (is_div_op) begin
              accept  = 1'b1;
`ifdef MULDIV_DIV0_TRAP_EN
              state_d = b_zero ? S_FIX : S_DIV;
`else
              state_d = S_DIV;
`endif
            end else if (bus.Function_opcode == F_MTHI) begin
              mthi_we = 1'b1;
            end else if (bus.Function_opcode == F_MTLO) begin
              mtlo_we = 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          iter = 1'b1;
          if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
        S_FIX: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
`ifdef MULDIV_DIV0_TRAP_EN
          if (div0_q) div_zero_d = 1'b1;
          else        fix_we     = 1'b1;
`else
          fix_we = 1'b1;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Operand latch, iteration registers and architectural HI/LO.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      hi_acc_q <= '0;
      lo_acc_q <= '0;
      op_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
`ifndef MULDIV_DIV0_TRAP_EN
      raw_a_q  <= '0;
`endif
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      done_q <= done_d;
`ifdef MULDIV_DIV0_TRAP_EN
      div_zero_q <= div_zero_d;
`endif
      if (accept) begin
        count_q  <= '0;
        hi_acc_q <= '0;
        is_div_q <= is_div_op;
        div0_q   <= b_zero;
        neg_lo_q <= a_neg ^ b_neg;
`ifndef MULDIV_DIV0_TRAP_EN
        raw_a_q  <= bus.Read_data_1;
`endif
        if (is_div_op) begin
          op_q     <= b_mag;
          lo_acc_q <= a_mag;
          neg_hi_q <= a_neg;           // remainder follows the dividend
        end else begin
          op_q     <= a_mag;
          lo_acc_q <= b_mag;
          neg_hi_q <= a_neg ^ b_neg;
        end
      end else if (iter) begin
        count_q  <= count_q + CW'(1);
        hi_acc_q <= hi_nxt;
        lo_acc_q <= lo_nxt;
      end

      if (mthi_we) hi_q <= bus.Read_data_1;
      if (mtlo_we) lo_q <= bus.Read_data_1;
      if (fix_we) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

  assign bus.Busy      = (state_q != S_IDLE);
  assign bus.Done      = done_q;
  assign bus.HI_result = hi_q;
  assign bus.LO_result = lo_q;
`ifdef MULDIV_DIV0_TRAP_EN
  assign bus.Div_zero  = div_zero_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: arithmetic, timing window, Flush, reset abort, divide by zero.
// Latency: cycle n is the interval after rising edge n-1; results expected at Start cycle + 34.
// Backpressure: exercises Start-while-Busy drop, Start coincident with Done, Flush priority.
module tb_hilo_muldiv_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  hilo_muldiv_ctrl_if #(.WIDTH(32)) bus ();

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one Start cycle; returns in the cycle after the Start edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.Start           = 1'b1;
    bus.Function_opcode = f;
    bus.Read_data_1     = a;
    bus.Read_data_2     = b;
    tick();
    bus.Start           = 1'b0;
  endtask

  initial begin
    int good;
    bus.Start           = 1'b0;
    bus.Flush           = 1'b0;
    bus.Function_opcode = 6'h00;
    bus.Read_data_1     = '0;
    bus.Read_data_2     = '0;
    ticks(2);
    reset = 1'b0;

    // Reset state
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    check("rst_hi",   64'(bus.HI_result), 64'd0);
    check("rst_lo",   64'(bus.LO_result), 64'd0);
`ifdef MULDIV_DIV0_TRAP_EN
    check("rst_dz",   64'(bus.Div_zero), 64'd0);
`endif

    // multu 0xFFFFFFFF^2: Busy exactly cycles 1..33, Done at 34
    issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    good = 0;
    for (int c = 1; c <= 33; c++) begin
      if (bus.Busy === 1'b1 && bus.Done === 1'b0) good++;
      tick();
    end
    check("multu_busy_window", 64'(good), 64'd33);
    check("multu_done",  64'(bus.Done), 64'd1);
    check("multu_busy0", 64'(bus.Busy), 64'd0);
    check("multu_hi", 64'(bus.HI_result), 64'hFFFF_FFFE);
    check("multu_lo", 64'(bus.LO_result), 64'h0000_0001);

    // mult -7*3 issued in the Done cycle; a stray divu during Busy is dropped
    issue(6'h18, 32'hFFFF_FFF9, 32'd3);
    check("coincident_accept_busy", 64'(bus.Busy), 64'd1);
    check("done_pulse_one_cycle",   64'(bus.Done), 64'd0);
    ticks(3);
    issue(6'h1B, 32'd100, 32'd7);
    ticks(29);
    check("mult_done", 64'(bus.Done), 64'd1);
    check("mult_hi", 64'(bus.HI_result), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.LO_result), 64'hFFFF_FFEB);
    tick();
    check("busy_start_dropped", 64'(bus.Busy), 64'd0);

    // div -7/2 (truncating)
    issue(6'h1A, 32'hFFFF_FFF9, 32'd2);
    ticks(33);
    check("div_done", 64'(bus.Done), 64'd1);
    check("div_lo", 64'(bus.LO_result), 64'hFFFF_FFFD);
    check("div_hi", 64'(bus.HI_result), 64'hFFFF_FFFF);

    // divu 100/7
    issue(6'h1B, 32'd100, 32'd7);
    ticks(33);
    check("divu_lo", 64'(bus.LO_result), 64'd14);
    check("divu_hi", 64'(bus.HI_result), 64'd2);

    // div most-negative / -1 wraps
    issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    ticks(33);
    check("divovf_lo", 64'(bus.LO_result), 64'h8000_0000);
    check("divovf_hi", 64'(bus.HI_result), 64'd0);

    // mthi then mtlo back-to-back
    issue(6'h11, 32'h0000_1234, 32'd0);
    check("mthi_hi",   64'(bus.HI_result), 64'h1234);
    check("mthi_busy", 64'(bus.Busy), 64'd0);
    check("mthi_done", 64'(bus.Done), 64'd0);
    issue(6'h13, 32'h0000_5678, 32'd0);
    check("mtlo_lo",   64'(bus.LO_result), 64'h5678);
    check("mtlo_hi",   64'(bus.HI_result), 64'h1234);
    check("mtlo_busy", 64'(bus.Busy), 64'd0);
    check("mtlo_done", 64'(bus.Done), 64'd0);

    // Flush together with Start in IDLE: nothing starts, mthi blocked too
    bus.Flush = 1'b1;
    issue(6'h18, 32'd2, 32'd3);
    check("flush_start_mul", 64'(bus.Busy), 64'd0);
    issue(6'h11, 32'h0000_DEAD, 32'd0);
    bus.Flush = 1'b0;
    check("flush_start_mthi", 64'(bus.HI_result), 64'h1234);

    // Flush at cycle 10 of a mult, restart at cycle 12
    issue(6'h18, 32'd2, 32'd3);
    ticks(9);
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    check("flush_busy11", 64'(bus.Busy), 64'd0);
    check("flush_done11", 64'(bus.Done), 64'd0);
    tick();
    check("flush_done12", 64'(bus.Done), 64'd0);
    check("flush_hi_kept", 64'(bus.HI_result), 64'h1234);
    check("flush_lo_kept", 64'(bus.LO_result), 64'h5678);
    issue(6'h18, 32'd2, 32'd3);
    ticks(32);
    check("restart_pre_hi",   64'(bus.HI_result), 64'h1234);
    check("restart_pre_done", 64'(bus.Done), 64'd0);
    tick();
    check("restart_done", 64'(bus.Done), 64'd1);
    check("restart_hi", 64'(bus.HI_result), 64'd0);
    check("restart_lo", 64'(bus.LO_result), 64'd6);

    // Divide by zero
`ifdef MULDIV_DIV0_TRAP_EN
    issue(6'h1B, 32'd5, 32'd0);
    check("dz_busy1", 64'(bus.Busy), 64'd1);
    check("dz_done1", 64'(bus.Done), 64'd0);
    tick();
    check("dz_done2", 64'(bus.Done), 64'd1);
    check("dz_flag2", 64'(bus.Div_zero), 64'd1);
    check("dz_busy2", 64'(bus.Busy), 64'd0);
    check("dz_hi_kept", 64'(bus.HI_result), 64'd0);
    check("dz_lo_kept", 64'(bus.LO_result), 64'd6);
    tick();
    check("dz_flag3", 64'(bus.Div_zero), 64'd0);
`else
    issue(6'h1B, 32'd5, 32'd0);
    ticks(33);
    check("dz_done", 64'(bus.Done), 64'd1);
    check("dz_lo", 64'(bus.LO_result), 64'hFFFF_FFFF);
    check("dz_hi", 64'(bus.HI_result), 64'd5);
    issue(6'h1A, 32'hFFFF_FFFB, 32'd0);
    ticks(33);
    check("dzs_lo", 64'(bus.LO_result), 64'hFFFF_FFFF);
    check("dzs_hi", 64'(bus.HI_result), 64'hFFFF_FFFB);
`endif

    // Reset at cycle 20 of a divide
    tick();
    issue(6'h1B, 32'd100, 32'd7);
    ticks(19);
    reset = 1'b1;
    tick();
    check("rstmid_busy", 64'(bus.Busy), 64'd0);
    check("rstmid_done", 64'(bus.Done), 64'd0);
    check("rstmid_hi", 64'(bus.HI_result), 64'd0);
    check("rstmid_lo", 64'(bus.LO_result), 64'd0);
    reset = 1'b0;
    ticks(15);
    check("rstmid_no_late_done", 64'(bus.Done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
